clasificador_pulsacion: RTL and testbench



---
 rtl/pkg_pulsacion.sv | 16 +
 rtl/detector_flanco.sv | 27 ++
 rtl/clasificador_pulsacion.sv | 115 +++++++++++
 tb/tb_clasificador_pulsacion.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_pulsacion.sv
// Shared types for the button gesture classifier: FSM states and sticky event codes.
package pkg_pulsacion;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PRESS1 = 2'b01,
        GAP    = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

endpackage

// File: rtl/detector_flanco.sv
// Rise/fall detector for a clk-synchronous level; reusable by any button consumer.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_level_q;
    logic r_armed;

    // r_armed masks the first cycle after reset so a level already high is not seen as a rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_level_q <= i_level;
            r_armed   <= 1'b1;
        end
    end

    assign o_rise_c = r_armed &  i_level & ~r_level_q;
    assign o_fall_c = r_armed & ~i_level &  r_level_q;

endmodule

// File: rtl/clasificador_pulsacion.sv
// Classifies debounced button gestures into short press, long press and double click events.
module clasificador_pulsacion
    import pkg_pulsacion::*;
#(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       btn_db,
    output logic       ev_short,
    output logic       ev_long,
    output logic       ev_double,
    output logic [1:0] ev_code,
    output logic       held,
    output logic [7:0] ev_count
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

    logic          w_rise;
    logic          w_fall;
    state_t        r_state;
    logic [TW-1:0] r_timer;

    detector_flanco u_detector (
        .clk      (clk),
        .reset    (reset),
        .i_level  (btn_db),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // Gesture FSM; pulses default low each cycle so every event lasts exactly one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            ev_short  <= 1'b0;
            ev_long   <= 1'b0;
            ev_double <= 1'b0;
            ev_code   <= EV_NONE;
            held      <= 1'b0;
            ev_count  <= 8'd0;
        end else begin
            ev_short  <= 1'b0;
            ev_long   <= 1'b0;
            ev_double <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                r_timer <= '0;
                held    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= PRESS1;
                            r_timer <= '0;
                        end
                    end
                    PRESS1: begin
                        if (w_fall) begin
                            r_state <= GAP;
                            r_timer <= '0;
                        end else if (btn_db && (r_timer == LONG_LAST)) begin
                            r_state  <= HOLD;
                            r_timer  <= '0;
                            ev_long  <= 1'b1;
                            ev_code  <= EV_LONG;
                            ev_count <= ev_count + 8'd1;
                            held     <= 1'b1;
                        end else if (r_timer != '1) begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    GAP: begin
                        if (w_rise) begin
                            r_state   <= HOLD;
                            r_timer   <= '0;
                            ev_double <= 1'b1;
                            ev_code   <= EV_DOUBLE;
                            ev_count  <= ev_count + 8'd1;
                            held      <= 1'b0;
                        end else if (r_timer == GAP_LAST) begin
                            r_state  <= IDLE;
                            r_timer  <= '0;
                            ev_short <= 1'b1;
                            ev_code  <= EV_SHORT;
                            ev_count <= ev_count + 8'd1;
                        end else if (r_timer != '1) begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    HOLD: begin
                        if (w_fall) begin
                            r_state <= IDLE;
                            r_timer <= '0;
                            held    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        held    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clasificador_pulsacion.sv
// Bench for clasificador_pulsacion: directed gestures plus random traffic against a timestamp-based model.
module tb_clasificador_pulsacion;

    localparam int unsigned LONG = 8;
    localparam int unsigned GAP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       btn_db;
    logic       ev_short;
    logic       ev_long;
    logic       ev_double;
    logic [1:0] ev_code;
    logic       held;
    logic [7:0] ev_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: gesture phase plus absolute cycle stamps
    int         cyc;
    int         phase;   // 0 released, 1 first press, 2 waiting for second press, 3 down after event
    int         t_mark;
    bit         m_prev;
    bit         m_primed;
    bit         x_short;
    bit         x_long;
    bit         x_double;
    bit         x_held;
    logic [1:0] x_code;
    logic [7:0] x_count;

    always #5 clk = ~clk;

    clasificador_pulsacion #(
        .LONG_CYCLES (LONG),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .btn_db    (btn_db),
        .ev_short  (ev_short),
        .ev_long   (ev_long),
        .ev_double (ev_double),
        .ev_code   (ev_code),
        .held      (held),
        .ev_count  (ev_count)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        phase    = 0;
        t_mark   = 0;
        m_prev   = 1'b0;
        m_primed = 1'b0;
        x_short  = 1'b0;
        x_long   = 1'b0;
        x_double = 1'b0;
        x_held   = 1'b0;
        x_code   = 2'b00;
        x_count  = 8'd0;
    endtask

    task automatic emit(input logic [1:0] code);
        x_code  = code;
        x_count = x_count + 8'd1;
    endtask

    task automatic model_step(input bit r, input bit e, input bit b);
        bit rise;
        bit fall;
        if (!r) begin
            model_reset();
            return;
        end
        x_short  = 1'b0;
        x_long   = 1'b0;
        x_double = 1'b0;
        cyc++;
        rise     = m_primed && b && !m_prev;
        fall     = m_primed && !b && m_prev;
        m_prev   = b;
        m_primed = 1'b1;
        if (!e) begin
            phase  = 0;
            x_held = 1'b0;
        end else begin
            case (phase)
                0: if (rise) begin phase = 1; t_mark = cyc; end
                1: begin
                    if (fall) begin
                        phase = 2; t_mark = cyc;
                    end else if (cyc - t_mark == int'(LONG)) begin
                        phase = 3; x_long = 1'b1; x_held = 1'b1; emit(2'b10);
                    end
                end
                2: begin
                    if (rise) begin
                        phase = 3; x_double = 1'b1; x_held = 1'b0; emit(2'b11);
                    end else if (cyc - t_mark == int'(GAP)) begin
                        phase = 0; x_short = 1'b1; emit(2'b01);
                    end
                end
                default: if (fall) begin phase = 0; x_held = 1'b0; end
            endcase
        end
    endtask

    task automatic check_all();
        chk("ev_short",  8'(ev_short),  8'(x_short));
        chk("ev_long",   8'(ev_long),   8'(x_long));
        chk("ev_double", 8'(ev_double), 8'(x_double));
        chk("ev_code",   8'(ev_code),   8'(x_code));
        chk("held",      8'(held),      8'(x_held));
        chk("ev_count",  ev_count,      x_count);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, then compare
    task automatic step(input bit r, input bit e, input bit b);
        reset  = r;
        en     = e;
        btn_db = b;
        @(posedge clk);
        model_step(r, e, b);
        @(negedge clk);
        check_all();
    endtask

    task automatic gesture(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < lo; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        btn_db = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        btn_db = 1'b1;
        en     = 1'b1;
        @(negedge clk);

        // Reset held with button down, then release: no rise, no events
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk("rst_count", ev_count, 8'd0);
        chk("rst_code", 8'(ev_code), 8'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        chk("rst_norise_count", ev_count, 8'd0);

        // Short press
        gesture(3, 6);
        chk("short_code", 8'(ev_code), 8'd1);
        chk("short_count", ev_count, 8'd1);

        // Long press, held visible after the long event
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
        chk("long_held", 8'(held), 8'd1);
        gesture(2, 6);
        chk("long_code", 8'(ev_code), 8'd2);
        chk("long_count", ev_count, 8'd2);

        // Double click
        gesture(2, 2);
        gesture(2, 6);
        chk("double_code", 8'(ev_code), 8'd3);
        chk("double_count", ev_count, 8'd3);

        // Second rise on the last gap cycle still counts as double
        gesture(2, 4);
        gesture(2, 6);
        chk("gap_edge_code", 8'(ev_code), 8'd3);
        chk("gap_edge_count", ev_count, 8'd4);

        // Release on the last press cycle: fall wins, short follows
        gesture(8, 6);
        chk("long_edge_code", 8'(ev_code), 8'd1);
        chk("long_edge_count", ev_count, 8'd5);

        // Enable dropped mid-press, restored with button still down
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        gesture(10, 6);
        chk("en_count", ev_count, 8'd5);
        chk("en_code", 8'(ev_code), 8'd1);

        // Counter wrap through zero
        for (int i = 0; i < 256; i++) begin
            gesture(2, 5);
            if (i == 250) chk("wrap_zero", ev_count, 8'd0);
        end
        chk("wrap_full", ev_count, 8'd5);

        // Asynchronous reset mid-gesture
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        chk("midrst_count", ev_count, 8'd0);

        // Random gestures with occasional enable drops
        for (int g = 0; g < 200; g++) begin
            int  hi;
            int  lo;
            bit  e;
            hi = int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 7));
            e  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < hi; i++) step(1'b1, e, 1'b1);
            e  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < lo; i++) step(1'b1, e, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
